// File: rtl/majority_vote_if.sv
// majority_vote_if: vote/result handshake bundle between a producer (master) and majority_vote_ctrl (slave)
interface majority_vote_if #(
  parameter int N = 4
);
  localparam int CW = $clog2(N + 1);
  logic start;
  logic vote_valid;
  logic vote_in;
  logic vote_ready;
  logic busy;
  logic res_valid;
  logic res_ready;
  logic majority;
  logic [CW-1:0] ones_count;
  logic timeout_err;
  modport master (
    output start, vote_valid, vote_in, res_ready,
    input  vote_ready, busy, res_valid, majority, ones_count, timeout_err
  );
  modport slave (
    input  start, vote_valid, vote_in, res_ready,
    output vote_ready, busy, res_valid, majority, ones_count, timeout_err
  );
endinterface

// File: rtl/majority_vote_ctrl.sv
// majority_vote_ctrl: sequential N-vote strict-majority ballot controller; MAJ_TIMEOUT_EN adds an idle timeout in COLLECT
module majority_vote_ctrl #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  majority_vote_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          maj_q, maj_d;
  logic          tout_q, tout_d;
  logic          acc;
  logic          expire;
  if (N < 1 || N > 255 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("majority_vote_ctrl: parameter out of range");
  end
  assign acc             = state_q == COLLECT && bus.vote_valid;
  assign bus.vote_ready  = state_q == COLLECT;
  assign bus.busy        = state_q != IDLE;
  assign bus.res_valid   = state_q == DONE;
  assign bus.majority    = maj_q;
  assign bus.ones_count  = cnt_q;
  assign bus.timeout_err = tout_q;
`ifdef MAJ_TIMEOUT_EN
  logic [15:0] tmr_q, tmr_d;
  assign tmr_d  = (state_q != COLLECT || acc) ? '0 : tmr_q + 16'd1;
  assign expire = state_q == COLLECT && !acc && tmr_q + 16'd1 == 16'(TIMEOUT);
  // idle timer: counts COLLECT cycles without an accepted vote
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
`else
  assign expire = 1'b0;
`endif
  // next-state and result computation; an accepted vote always beats timer expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    maj_d   = maj_q;
    tout_d  = tout_q;
    if (state_q == IDLE && bus.start) begin
      state_d = COLLECT;
      cnt_d   = '0;
      idx_d   = '0;
      tout_d  = 1'b0;
    end else if (acc) begin
      cnt_d = cnt_q + CW'(bus.vote_in);
      idx_d = idx_q + 1'b1;
      if (idx_q == CW'(N - 1)) begin
        state_d = DONE;
        maj_d   = cnt_d > CW'(N / 2);
      end
    end else if (expire) begin
      state_d = DONE;
      tout_d  = 1'b1;
      maj_d   = 1'b0;
    end else if (state_q == DONE && bus.res_ready) begin
      state_d = IDLE;
    end
  end
  // ballot state and registered result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      maj_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      maj_q   <= maj_d;
      tout_q  <= tout_d;
    end
endmodule

// File: tb/tb_majority_vote_ctrl.sv
// tb_majority_vote_ctrl: table-driven, hand-sequenced and randomized checks of majority_vote_ctrl (N=4)
module tb_majority_vote_ctrl;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  majority_vote_if #(.N(N)) bus ();
  majority_vote_ctrl #(.N(N), .TIMEOUT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [N-1:0] votes;
    int           gap;
    logic         maj;
    int           cnt;
  } vec_t;
  vec_t tbl[7];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] outs();
    return {bus.vote_ready, bus.busy, bus.res_valid, bus.majority, bus.ones_count, bus.timeout_err};
  endfunction
  function automatic logic [7:0] pk(input bit vr, input bit bz, input bit rv, input bit mj, input int cnt, input bit to);
    return {vr, bz, rv, mj, 3'(cnt), to};
  endfunction
  function automatic logic [2:0] ctl();
    return {bus.vote_ready, bus.busy, bus.res_valid};
  endfunction
  task automatic run_ballot(input logic [N-1:0] votes, input int gap, input logic maj, input int cnt, input bit hs);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("collect_ctl", ctl(), 3'b110);
    chk("collect_cnt", bus.ones_count, 0);
    for (int i = 0; i < N; i++) begin
      repeat (gap) begin
        bus.vote_valid = 1'b0;
        tick();
        chk("gap_no_res", bus.res_valid, 0);
      end
      bus.vote_valid = 1'b1;
      bus.vote_in = votes[i];
      tick();
      if (i < N - 1) chk("early_res", bus.res_valid, 0);
    end
    bus.vote_valid = 1'b0;
    chk("result", outs(), pk(0, 1, 1, maj, cnt, 0));
    if (hs) begin
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("idle_after_hs", ctl(), 3'b000);
      chk("cnt_held_idle", bus.ones_count, cnt);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.vote_valid = 1'b0;
    bus.vote_in = 1'b0;
    bus.res_ready = 1'b0;
    tbl[0] = '{4'b0111, 0, 1'b1, 3};
    tbl[1] = '{4'b1100, 2, 1'b0, 2};
    tbl[2] = '{4'b0000, 0, 1'b0, 0};
    tbl[3] = '{4'b1111, 1, 1'b1, 4};
    tbl[4] = '{4'b1000, 0, 1'b0, 1};
    tbl[5] = '{4'b1011, 3, 1'b1, 3};
    tbl[6] = '{4'b0101, 0, 1'b0, 2};
    repeat (2) tick();
    chk("in_reset", outs(), 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_no_start", outs(), 8'h00);
    end
    foreach (tbl[i]) run_ballot(tbl[i].votes, tbl[i].gap, tbl[i].maj, tbl[i].cnt, 1'b1);
    run_ballot(4'b0111, 0, 1'b1, 3, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.start = c[0];
      bus.vote_valid = ~c[0];
      bus.vote_in = 1'b1;
      tick();
      chk("done_hold", outs(), pk(0, 1, 1, 1, 3, 0));
    end
    bus.start = 1'b0;
    bus.vote_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("hs_to_idle", ctl(), 3'b000);
    tick();
    chk("still_idle", ctl(), 3'b000);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.vote_valid = 1'b1;
    bus.vote_in = 1'b1;
    repeat (2) tick();
    bus.vote_valid = 1'b0;
    chk("pre_reset_cnt", bus.ones_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 8'h00);
    tick();
    chk("held_reset", outs(), 8'h00);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", outs(), 8'h00);
    run_ballot(4'b1111, 0, 1'b1, 4, 1'b1);
    for (int b = 0; b < 30; b++) begin
      logic vq[$];
      int acc_n;
      int ones;
      vq = {};
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("rnd_collect", ctl(), 3'b110);
      acc_n = 0;
      while (acc_n < N) begin
        bus.vote_valid = 1'($urandom_range(0, 2) != 0);
        bus.vote_in = 1'($urandom);
        bus.start = 1'($urandom);
        if (bus.vote_valid) begin
          vq.push_back(bus.vote_in);
          acc_n++;
        end
        tick();
        chk("rnd_res_valid", bus.res_valid, acc_n == N);
      end
      bus.vote_valid = 1'b0;
      bus.start = 1'b0;
      ones = 0;
      foreach (vq[i]) ones += int'(vq[i]);
      repeat ($urandom_range(0, 3)) begin
        bus.vote_valid = 1'($urandom);
        tick();
        chk("rnd_hold", outs(), pk(0, 1, 1, 2 * ones > N, ones, 0));
      end
      bus.vote_valid = 1'b0;
      chk("rnd_result", outs(), pk(0, 1, 1, 2 * ones > N, ones, 0));
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("rnd_idle", ctl(), 3'b000);
    end
`ifdef MAJ_TIMEOUT_EN
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.vote_valid = 1'b1;
    bus.vote_in = 1'b1;
    tick();
    bus.vote_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_not_yet", bus.res_valid, 0);
    end
    tick();
    chk("timeout_result", outs(), pk(0, 1, 1, 0, 1, 1));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("timeout_idle", ctl(), 3'b000);
    run_ballot(4'b0111, 0, 1'b1, 3, 1'b1);
    chk("timeout_err_cleared", bus.timeout_err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
